mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: cycles to wait for mem_resp before abort (used only with timeout compiled in).
REQ-002 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port cpu_read, input, 1: word or byte load request, sampled in IDLE.
REQ-005 SHALL have port cpu_write, input, 1: store request, sampled in IDLE.
REQ-006 SHALL have port cpu_ldb / cpu_stb, input, 1 each: byte load / byte store qualifiers.
REQ-007 SHALL have port cpu_addr, input, lc3b_word (16): access address.
REQ-008 SHALL have port cpu_wdata, input, lc3b_word (16): store data.
REQ-009 SHALL have port cpu_wmask, input, lc3b_mem_wmask (2): byte enables from the byte-select stage.
REQ-010 SHALL have port cpu_byte_sel, input, 1: high-byte select for loads.
REQ-011 SHALL have ports cpu_resp (output, 1): completion pulse; cpu_err (output, 1): abort flag; cpu_busy (output, 1): unit not idle.
REQ-012 SHALL have port cpu_rdata, output, lc3b_word (16): formatted load data.
REQ-013 SHALL have ports mem_read, mem_write (output, 1), mem_address, mem_wdata (output, 16), mem_byte_enable (output, lc3b_mem_wmask): memory request.
REQ-014 SHALL have ports mem_resp (input, 1), mem_rdata (input, 16): memory completion and read data.

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-016 IDLE: on cpu_read or cpu_write, SHALL capture addr, wdata, wmask, byte_sel, ldb, stb, and op, then go to ACCESS next edge; read wins if both asserted.
REQ-017 ACCESS: SHALL drive mem_read or mem_write = 1 from registered state, with mem_address, mem_wdata and mem_byte_enable held stable until mem_resp.
REQ-018 mem_byte_enable SHALL be the captured wmask for writes and 2'b11 for reads.
REQ-019 Byte store: mem_wdata SHALL be {wdata[7:0], wdata[7:0]}; otherwise captured wdata.
REQ-020 ACCESS with mem_resp=1: SHALL register formatted load data and go to RESP; mem_read/mem_write deassert that next cycle.
REQ-021 Load formatting:
  - ldb: {8'h00, byte_sel ? mem_rdata[15:8] : mem_rdata[7:0]}.
  - word load: mem_rdata unchanged.
  - write: cpu_rdata unchanged.
REQ-022 RESP: cpu_resp=1 for exactly one cycle, then IDLE; cpu_rdata holds its value until the next load completes.
REQ-023 Latency: request sampled at edge 0 -> mem request in cycle 1 -> cpu_resp in cycle after mem_resp; minimum 3 cycles.
REQ-024 cpu_busy SHALL equal (state != IDLE); cpu requests while busy SHALL be ignored, not queued.
REQ-025 mem_resp in IDLE or RESP SHALL be ignored.
REQ-026 A new request asserted in the cycle RESP returns to IDLE SHALL be accepted in IDLE the following cycle (no back-to-back in RESP).

Reset
REQ-027 reset SHALL force IDLE and clear all of these to 0:
  - mem_read, mem_write, cpu_resp, cpu_err, cpu_busy, cpu_rdata
  - mem_address, mem_wdata, wait counter
  - mem_byte_enable to 2'b11.
REQ-028 reset mid-ACCESS SHALL drop the request next cycle with no cpu_resp; a later mem_resp SHALL be ignored.

Configuration
REQ-029 With MEM_ACCESS_TIMEOUT_EN defined:
  - an ACCESS wait counter SHALL count cycles.
  - on reaching TIMEOUT_CYCLES without mem_resp, SHALL go to RESP with cpu_err=1 alongside cpu_resp and cpu_rdata unchanged.
  - the counter SHALL clear on entry to ACCESS.
REQ-030 Without MEM_ACCESS_TIMEOUT_EN, cpu_err SHALL be constant 0, no counter SHALL exist, and ACCESS SHALL wait indefinitely.

Structure
REQ-031 The state enum mem_access_state_t SHALL be added to package lc3b_types; lc3b_word and lc3b_mem_wmask SHALL come from it.
REQ-032 Load formatting SHALL be sub-module mem_load_format (combinational: mem_rdata, ldb, byte_sel -> formatted word).

Verification
REQ-033 Word load: addr 16'h3000, mem_rdata 16'hBEEF, mem_resp after 2 cycles -> cpu_rdata 16'hBEEF, one cpu_resp pulse, mem_byte_enable 2'b11.
REQ-034 LDB: byte_sel=1, mem_rdata 16'hA55A -> cpu_rdata 16'h00A5; byte_sel=0 -> 16'h005A.
REQ-035 STB: wmask 2'b10, wdata 16'h1234 -> mem_write=1, mem_wdata 16'h3434, mem_byte_enable 2'b10 until mem_resp.
REQ-036 Busy and simultaneous requests:
  - cpu_write pulsed during ACCESS -> ignored.
  - cpu_read+cpu_write together in IDLE -> mem_read only.
REQ-037 reset asserted in ACCESS -> mem_read 0 next cycle, no cpu_resp; later stray mem_resp -> no response.
REQ-038 MEM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no mem_resp -> cpu_resp with cpu_err=1 after 4 ACCESS cycles.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// lc3b_types: shared types for the LC-3b memory access unit.
//   lc3b_word          - 16-bit data / address word
//   lc3b_mem_wmask     - 2-bit byte enable mask
//   mem_access_state_t - access sequencer states (IDLE -> ACCESS -> RESP)
//   mem_op_t           - captured operation kind
//   byte_replicate     - copies a byte into both lanes for byte stores
// -----------------------------------------------------------------------------
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        MA_IDLE   = 2'b00,
        MA_ACCESS = 2'b01,
        MA_RESP   = 2'b10
    } mem_access_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

    // A byte store puts the low byte on both lanes; the byte enables pick the lane.
    function automatic lc3b_word byte_replicate(input logic [7:0] b);
        return {b, b};
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// Bus interfaces of the memory access unit.
//   mem_access_unit_cpu_if : CPU-side request/response bus.
//       master = CPU (drives requests), slave = access unit (drives response).
//   mem_access_unit_mem_if : memory-side bus.
//       master = access unit (drives request), slave = memory (drives response).
// -----------------------------------------------------------------------------
interface mem_access_unit_cpu_if;
    import lc3b_types::*;

    logic          cpu_read;
    logic          cpu_write;
    logic          cpu_ldb;
    logic          cpu_stb;
    lc3b_word      cpu_addr;
    lc3b_word      cpu_wdata;
    lc3b_mem_wmask cpu_wmask;
    logic          cpu_byte_sel;
    logic          cpu_resp;
    logic          cpu_err;
    logic          cpu_busy;
    lc3b_word      cpu_rdata;

    modport master (
        output cpu_read, cpu_write, cpu_ldb, cpu_stb, cpu_addr, cpu_wdata,
               cpu_wmask, cpu_byte_sel,
        input  cpu_resp, cpu_err, cpu_busy, cpu_rdata
    );

    modport slave (
        input  cpu_read, cpu_write, cpu_ldb, cpu_stb, cpu_addr, cpu_wdata,
               cpu_wmask, cpu_byte_sel,
        output cpu_resp, cpu_err, cpu_busy, cpu_rdata
    );
endinterface

interface mem_access_unit_mem_if;
    import lc3b_types::*;

    logic          mem_read;
    logic          mem_write;
    lc3b_word      mem_address;
    lc3b_word      mem_wdata;
    lc3b_mem_wmask mem_byte_enable;
    logic          mem_resp;
    lc3b_word      mem_rdata;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_resp, mem_rdata
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_resp, mem_rdata
    );
endinterface

// File: rtl/mem_access_unit_load_format.sv
// -----------------------------------------------------------------------------
// mem_load_format: combinational load data formatter.
//   mem_rdata_i - raw word returned by memory
//   ldb_i       - byte load: zero-extend the selected byte
//   byte_sel_i  - selects the high byte for byte loads
//   data_o      - formatted load word
// -----------------------------------------------------------------------------
module mem_load_format
    import lc3b_types::*;
(
    input  lc3b_word mem_rdata_i,
    input  logic     ldb_i,
    input  logic     byte_sel_i,
    output lc3b_word data_o
);

    // Select and zero-extend the addressed byte, or pass the full word through.
    always_comb begin
        data_o = mem_rdata_i;
        if (ldb_i) begin
            if (byte_sel_i) begin
                data_o = {8'h00, mem_rdata_i[15:8]};
            end else begin
                data_o = {8'h00, mem_rdata_i[7:0]};
            end
        end else begin
            data_o = mem_rdata_i;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit: sequences one CPU load/store onto the memory bus.
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   cpu   - CPU request/response bus (slave side)
//   mem   - memory request/response bus (master side)
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES cycles without mem_resp (reported via cpu_err with cpu_resp).
// Without it cpu_err is tied low and ACCESS waits forever.
// -----------------------------------------------------------------------------
module mem_access_unit
    import lc3b_types::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_access_unit_cpu_if.slave  cpu,
    mem_access_unit_mem_if.master mem
);

    mem_access_state_t state_q, state_d;
    mem_op_t           op_q, op_d;
    logic              ldb_q, ldb_d;
    logic              byte_sel_q, byte_sel_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    lc3b_word          mem_address_q, mem_address_d;
    lc3b_word          mem_wdata_q, mem_wdata_d;
    lc3b_mem_wmask     mem_be_q, mem_be_d;
    logic              cpu_resp_q, cpu_resp_d;
    logic              cpu_busy_q, cpu_busy_d;
    lc3b_word          cpu_rdata_q, cpu_rdata_d;
    logic              cpu_err_d;
    lc3b_word          fmt_s;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              cpu_err_q;
`endif

    mem_load_format u_load_format (
        .mem_rdata_i (mem.mem_rdata),
        .ldb_i       (ldb_q),
        .byte_sel_i  (byte_sel_q),
        .data_o      (fmt_s)
    );

    // Next-state and output-register logic of the access sequencer.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        ldb_d         = ldb_q;
        byte_sel_d    = byte_sel_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_be_d      = mem_be_q;
        cpu_resp_d    = 1'b0;
        cpu_rdata_d   = cpu_rdata_q;
        cpu_err_d     = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        wait_d        = wait_q;
`endif
        case (state_q)
            MA_IDLE: begin
                if (cpu.cpu_read || cpu.cpu_write) begin
                    // Read wins when both are requested together.
                    state_d       = MA_ACCESS;
                    op_d          = cpu.cpu_read ? OP_READ : OP_WRITE;
                    ldb_d         = cpu.cpu_ldb;
                    byte_sel_d    = cpu.cpu_byte_sel;
                    mem_read_d    = cpu.cpu_read;
                    mem_write_d   = ~cpu.cpu_read;
                    mem_address_d = cpu.cpu_addr;
                    mem_wdata_d   = (!cpu.cpu_read && cpu.cpu_stb) ?
                                    byte_replicate(cpu.cpu_wdata[7:0]) : cpu.cpu_wdata;
                    mem_be_d      = cpu.cpu_read ? 2'b11 : cpu.cpu_wmask;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    wait_d        = {WAIT_W{1'b0}};
`endif
                end else begin
                    state_d = MA_IDLE;
                end
            end
            MA_ACCESS: begin
                if (mem.mem_resp) begin
                    state_d     = MA_RESP;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    cpu_resp_d  = 1'b1;
                    if (op_q == OP_READ) begin
                        cpu_rdata_d = fmt_s;
                    end else begin
                        cpu_rdata_d = cpu_rdata_q;
                    end
                end
`ifdef MEM_ACCESS_TIMEOUT_EN
                else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Last allowed ACCESS cycle elapsed: abort, keep cpu_rdata.
                    state_d     = MA_RESP;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    cpu_resp_d  = 1'b1;
                    cpu_err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
`else
                else begin
                    state_d = MA_ACCESS;
                end
`endif
            end
            MA_RESP: begin
                state_d = MA_IDLE;
            end
            default: begin
                state_d     = MA_IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
        cpu_busy_d = (state_d != MA_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= MA_IDLE;
            op_q          <= OP_READ;
            ldb_q         <= 1'b0;
            byte_sel_q    <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= 16'h0000;
            mem_wdata_q   <= 16'h0000;
            mem_be_q      <= 2'b11;
            cpu_resp_q    <= 1'b0;
            cpu_busy_q    <= 1'b0;
            cpu_rdata_q   <= 16'h0000;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            ldb_q         <= ldb_d;
            byte_sel_q    <= byte_sel_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_be_q      <= mem_be_d;
            cpu_resp_q    <= cpu_resp_d;
            cpu_busy_q    <= cpu_busy_d;
            cpu_rdata_q   <= cpu_rdata_d;
        end
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    // Timeout wait counter and abort flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q    <= {WAIT_W{1'b0}};
            cpu_err_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            cpu_err_q <= cpu_err_d;
        end
    end

    assign cpu.cpu_err = cpu_err_q;
`else
    assign cpu.cpu_err = 1'b0;
`endif

    assign cpu.cpu_resp        = cpu_resp_q;
    assign cpu.cpu_busy        = cpu_busy_q;
    assign cpu.cpu_rdata       = cpu_rdata_q;
    assign mem.mem_read        = mem_read_q;
    assign mem.mem_write       = mem_write_q;
    assign mem.mem_address     = mem_address_q;
    assign mem.mem_wdata       = mem_wdata_q;
    assign mem.mem_byte_enable = mem_be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// Self-checking bench for mem_access_unit. The reference model tracks the
// expected transaction (request lines, formatted load data, response timing)
// from the functional rules; the timeout scenario runs only when
// MEM_ACCESS_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES = 4).
// -----------------------------------------------------------------------------
module tb_mem_access_unit;
    import lc3b_types::*;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
    localparam int MAX_DELAY  = 2;
`else
    localparam int TB_TIMEOUT = 64;
    localparam int MAX_DELAY  = 5;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    lc3b_word model_rdata = 16'h0000;

    // Request raised during RESP by the back-to-back scenario.
    logic          nx_rd, nx_wr;
    lc3b_word      nx_addr;

    mem_access_unit_cpu_if cpu_bus ();
    mem_access_unit_mem_if mem_bus ();

    mem_access_unit #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .cpu   (cpu_bus.slave),
        .mem   (mem_bus.master)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_bus.cpu_read     = 1'b0;
        cpu_bus.cpu_write    = 1'b0;
        cpu_bus.cpu_ldb      = 1'b0;
        cpu_bus.cpu_stb      = 1'b0;
        cpu_bus.cpu_addr     = 16'h0000;
        cpu_bus.cpu_wdata    = 16'h0000;
        cpu_bus.cpu_wmask    = 2'b00;
        cpu_bus.cpu_byte_sel = 1'b0;
        mem_bus.mem_resp     = 1'b0;
        mem_bus.mem_rdata    = 16'h0000;
    endtask

    // One complete transaction, checked cycle by cycle against the model.
    task automatic txn(input logic rd, input logic wr, input logic ldb, input logic stb,
                       input lc3b_word addr, input lc3b_word wdata, input lc3b_mem_wmask wmask,
                       input logic bsel, input lc3b_word rdata, input int delay,
                       input logic poke, input logic stray, input logic chain, input string nm);
        lc3b_mem_wmask e_be;
        lc3b_word      e_wd, e_rd, lo, hi;
        logic          e_rdop;
        e_rdop = rd;
        e_be   = rd ? 2'b11 : wmask;
        lo     = {8'h00, wdata[7:0]};
        e_wd   = (!rd && stb) ? ((lo << 8) | lo) : wdata;
        if (rd) begin
            if (ldb) e_rd = bsel ? (rdata >> 8) : (rdata & 16'h00FF);
            else     e_rd = rdata;
        end else begin
            e_rd = model_rdata;
        end
        hi = 16'h0000;
        mem_bus.mem_resp     = 1'b0;
        cpu_bus.cpu_read     = rd;
        cpu_bus.cpu_write    = wr;
        cpu_bus.cpu_ldb      = ldb;
        cpu_bus.cpu_stb      = stb;
        cpu_bus.cpu_addr     = addr;
        cpu_bus.cpu_wdata    = wdata;
        cpu_bus.cpu_wmask    = wmask;
        cpu_bus.cpu_byte_sel = bsel;
        step();
        cpu_bus.cpu_read  = 1'b0;
        cpu_bus.cpu_write = 1'b0;
        for (int i = 0; i <= delay; i++) begin
            if (i == delay) begin
                mem_bus.mem_resp  = 1'b1;
                mem_bus.mem_rdata = rdata;
            end else begin
                mem_bus.mem_rdata = 16'($urandom);
            end
            if (poke && i == 0) begin
                cpu_bus.cpu_read  = 1'b1;
                cpu_bus.cpu_write = 1'b1;
                cpu_bus.cpu_addr  = 16'($urandom);
            end
            n_tests++;
            if (mem_bus.mem_read !== e_rdop || mem_bus.mem_write !== !e_rdop) begin
                n_fail++;
                $display("FAIL %s access_rw cyc %0d: got r=%b w=%b want r=%b w=%b",
                         nm, i, mem_bus.mem_read, mem_bus.mem_write, e_rdop, !e_rdop);
            end
            n_tests++;
            if (mem_bus.mem_address !== addr || mem_bus.mem_wdata !== e_wd ||
                mem_bus.mem_byte_enable !== e_be) begin
                n_fail++;
                $display("FAIL %s access_bus cyc %0d: got a=%h d=%h be=%b want a=%h d=%h be=%b",
                         nm, i, mem_bus.mem_address, mem_bus.mem_wdata,
                         mem_bus.mem_byte_enable, addr, e_wd, e_be);
            end
            n_tests++;
            if (cpu_bus.cpu_busy !== 1'b1 || cpu_bus.cpu_resp !== 1'b0 ||
                cpu_bus.cpu_rdata !== model_rdata) begin
                n_fail++;
                $display("FAIL %s access_cpu cyc %0d: got busy=%b resp=%b rdata=%h want 1 0 %h",
                         nm, i, cpu_bus.cpu_busy, cpu_bus.cpu_resp, cpu_bus.cpu_rdata, model_rdata);
            end
            step();
            cpu_bus.cpu_read  = 1'b0;
            cpu_bus.cpu_write = 1'b0;
        end
        mem_bus.mem_resp  = stray;
        mem_bus.mem_rdata = 16'($urandom);
        if (chain) begin
            cpu_bus.cpu_read  = nx_rd;
            cpu_bus.cpu_write = nx_wr;
            cpu_bus.cpu_addr  = nx_addr;
        end
        n_tests++;
        if (cpu_bus.cpu_resp !== 1'b1 || cpu_bus.cpu_err !== 1'b0 || cpu_bus.cpu_rdata !== e_rd ||
            cpu_bus.cpu_busy !== 1'b1 || mem_bus.mem_read !== 1'b0 || mem_bus.mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL %s resp: got resp=%b err=%b rdata=%h busy=%b r=%b w=%b want 1 0 %h 1 0 0",
                     nm, cpu_bus.cpu_resp, cpu_bus.cpu_err, cpu_bus.cpu_rdata, cpu_bus.cpu_busy,
                     mem_bus.mem_read, mem_bus.mem_write, e_rd);
        end
        model_rdata = e_rd;
        step();
        n_tests++;
        if (cpu_bus.cpu_resp !== 1'b0 || cpu_bus.cpu_busy !== 1'b0 || cpu_bus.cpu_rdata !== model_rdata ||
            mem_bus.mem_read !== 1'b0 || mem_bus.mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle: got resp=%b busy=%b rdata=%h r=%b w=%b want 0 0 %h 0 0",
                     nm, cpu_bus.cpu_resp, cpu_bus.cpu_busy, cpu_bus.cpu_rdata,
                     mem_bus.mem_read, mem_bus.mem_write, model_rdata);
        end
        if (!chain) begin
            mem_bus.mem_resp = 1'b0;
            step();
            n_tests++;
            if (cpu_bus.cpu_busy !== 1'b0 || cpu_bus.cpu_resp !== hi[0] || mem_bus.mem_read !== 1'b0 ||
                mem_bus.mem_write !== 1'b0) begin
                n_fail++;
                $display("FAIL %s stay_idle: got busy=%b resp=%b r=%b w=%b want 0 0 0 0",
                         nm, cpu_bus.cpu_busy, cpu_bus.cpu_resp, mem_bus.mem_read, mem_bus.mem_write);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        n_tests++;
        if (mem_bus.mem_read !== 1'b0 || mem_bus.mem_write !== 1'b0 || cpu_bus.cpu_resp !== 1'b0 ||
            cpu_bus.cpu_err !== 1'b0 || cpu_bus.cpu_busy !== 1'b0 || cpu_bus.cpu_rdata !== 16'h0000 ||
            mem_bus.mem_address !== 16'h0000 || mem_bus.mem_wdata !== 16'h0000 ||
            mem_bus.mem_byte_enable !== 2'b11) begin
            n_fail++;
            $display("FAIL reset: got r=%b w=%b resp=%b err=%b busy=%b rd=%h a=%h d=%h be=%b want zeros, be=11",
                     mem_bus.mem_read, mem_bus.mem_write, cpu_bus.cpu_resp, cpu_bus.cpu_err,
                     cpu_bus.cpu_busy, cpu_bus.cpu_rdata, mem_bus.mem_address,
                     mem_bus.mem_wdata, mem_bus.mem_byte_enable);
        end
        reset = 1'b0;
        model_rdata = 16'h0000;
        step();
    endtask

    task automatic test_directed();
        txn(1'b1, 1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000, 2'b00, 1'b0, 16'hBEEF, 2, 1'b0, 1'b0, 1'b0, "word_load");
        txn(1'b1, 1'b0, 1'b1, 1'b0, 16'h3002, 16'h0000, 2'b00, 1'b1, 16'hA55A, 0, 1'b0, 1'b0, 1'b0, "ldb_hi");
        txn(1'b1, 1'b0, 1'b1, 1'b0, 16'h3004, 16'h0000, 2'b00, 1'b0, 16'hA55A, 1, 1'b0, 1'b0, 1'b0, "ldb_lo");
        txn(1'b0, 1'b1, 1'b0, 1'b1, 16'h4001, 16'h1234, 2'b10, 1'b0, 16'hFFFF, 3, 1'b0, 1'b0, 1'b0, "stb");
        txn(1'b0, 1'b1, 1'b0, 1'b0, 16'h4002, 16'hCAFE, 2'b11, 1'b0, 16'h0000, 0, 1'b0, 1'b1, 1'b0, "stw_stray");
    endtask

    task automatic test_busy_and_simultaneous();
        txn(1'b0, 1'b1, 1'b0, 1'b0, 16'h5000, 16'h7777, 2'b01, 1'b0, 16'h0000, 2, 1'b1, 1'b0, 1'b0, "busy_ignore");
        txn(1'b1, 1'b1, 1'b0, 1'b1, 16'h5002, 16'h9999, 2'b01, 1'b0, 16'h1357, 1, 1'b0, 1'b0, 1'b0, "read_wins");
    endtask

    task automatic test_back_to_back();
        nx_rd = 1'b1;
        nx_wr = 1'b0;
        nx_addr = 16'h6100;
        txn(1'b0, 1'b1, 1'b0, 1'b0, 16'h6000, 16'h2468, 2'b11, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 1'b1, "b2b_first");
        txn(1'b1, 1'b0, 1'b0, 1'b0, 16'h6100, 16'h0000, 2'b00, 1'b0, 16'h8642, 0, 1'b0, 1'b0, 1'b0, "b2b_second");
    endtask

    task automatic test_reset_mid_access();
        idle_inputs();
        cpu_bus.cpu_read = 1'b1;
        cpu_bus.cpu_addr = 16'h7000;
        step();
        cpu_bus.cpu_read = 1'b0;
        n_tests++;
        if (mem_bus.mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid pre: mem_read got %b want 1", mem_bus.mem_read);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_rdata = 16'h0000;
        n_tests++;
        if (mem_bus.mem_read !== 1'b0 || cpu_bus.cpu_resp !== 1'b0 || cpu_bus.cpu_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid drop: got r=%b resp=%b busy=%b want 0 0 0",
                     mem_bus.mem_read, cpu_bus.cpu_resp, cpu_bus.cpu_busy);
        end
        mem_bus.mem_resp  = 1'b1;
        mem_bus.mem_rdata = 16'hDEAD;
        step();
        mem_bus.mem_resp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (cpu_bus.cpu_resp !== 1'b0 || cpu_bus.cpu_busy !== 1'b0 || cpu_bus.cpu_rdata !== model_rdata) begin
                n_fail++;
                $display("FAIL rst_mid stray cyc %0d: got resp=%b busy=%b rdata=%h want 0 0 %h",
                         i, cpu_bus.cpu_resp, cpu_bus.cpu_busy, cpu_bus.cpu_rdata, model_rdata);
            end
            step();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            logic rd, wr;
            int   sel;
            sel = int'($urandom_range(0, 2));
            rd  = (sel != 1);
            wr  = (sel != 0);
            txn(rd, wr, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 2'($urandom),
                1'($urandom), 16'($urandom), int'($urandom_range(0, MAX_DELAY)),
                1'($urandom), 1'($urandom), 1'b0, "random");
        end
    endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
    task automatic test_timeout();
        idle_inputs();
        cpu_bus.cpu_read = 1'b1;
        cpu_bus.cpu_addr = 16'h7700;
        step();
        cpu_bus.cpu_read = 1'b0;
        for (int i = 0; i < TB_TIMEOUT; i++) begin
            n_tests++;
            if (mem_bus.mem_read !== 1'b1 || cpu_bus.cpu_resp !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout wait cyc %0d: got r=%b resp=%b want 1 0",
                         i, mem_bus.mem_read, cpu_bus.cpu_resp);
            end
            step();
        end
        n_tests++;
        if (cpu_bus.cpu_resp !== 1'b1 || cpu_bus.cpu_err !== 1'b1 || cpu_bus.cpu_rdata !== model_rdata ||
            mem_bus.mem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout abort: got resp=%b err=%b rdata=%h r=%b want 1 1 %h 0",
                     cpu_bus.cpu_resp, cpu_bus.cpu_err, cpu_bus.cpu_rdata, mem_bus.mem_read, model_rdata);
        end
        step();
        n_tests++;
        if (cpu_bus.cpu_resp !== 1'b0 || cpu_bus.cpu_err !== 1'b0 || cpu_bus.cpu_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout after: got resp=%b err=%b busy=%b want 0 0 0",
                     cpu_bus.cpu_resp, cpu_bus.cpu_err, cpu_bus.cpu_busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_busy_and_simultaneous();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
`ifdef MEM_ACCESS_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
